// File: rtl/prio_code_sequencer_if.sv
// Request-in / code-out stream bundle for prio_code_sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface prio_code_sequencer_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CODE_W = $clog2(WIDTH)
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_vec;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_last;
    logic              out_none;
    logic [CODE_W:0]   out_beat;

    modport slave (
        input  flush, in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_code, out_last, out_none, out_beat
    );

    modport master (
        output flush, in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_code, out_last, out_none, out_beat
    );
endinterface

// File: rtl/prio_code_sequencer.sv
// Captures a request vector and streams the code of each set bit, one per beat,
// in priority order; an all-zero vector yields a single "none" beat with code 0.
module prio_code_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CODE_W     = $clog2(WIDTH),
    parameter int unsigned DESCENDING = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    prio_code_sequencer_if.slave  bus
);

    localparam int unsigned BEAT_W = CODE_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    pending, pending_nxt;
    logic [BEAT_W-1:0]   beat, beat_nxt;
    logic                zero_flag, zero_nxt;

    logic [CODE_W-1:0]   sel_code;
    logic [WIDTH-1:0]    sel_mask;
    logic                single_bit;

    logic                in_ready;
    logic                out_valid;
    logic [CODE_W-1:0]   out_code;
    logic                out_last;
    logic                out_none;
    logic [BEAT_W-1:0]   out_beat;

    // Priority pick over the held vector; later loop iterations win.
    always_comb begin
        sel_code = '0;
        if (DESCENDING != 0) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (pending[i]) sel_code = CODE_W'(i);
            end
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (pending[i]) sel_code = CODE_W'(i);
            end
        end
    end

    assign sel_mask   = WIDTH'(1) << sel_code;
    assign single_bit = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            beat      <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            beat      <= beat_nxt;
            zero_flag <= zero_nxt;
        end
    end

    // Next-state and stream outputs; outputs decode only registered state,
    // in_ready alone looks at out_ready/flush to allow a bubble-free reload.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        beat_nxt    = beat;
        zero_nxt    = zero_flag;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_code    = '0;
        out_last    = 1'b0;
        out_none    = 1'b0;
        out_beat    = '0;

        unique case (state)
            IDLE: begin
                in_ready = !bus.flush;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_code  = zero_flag ? '0 : sel_code;
                out_last  = zero_flag || single_bit;
                out_none  = zero_flag;
                out_beat  = beat;
                in_ready  = bus.out_ready && out_last && !bus.flush;
                if (bus.out_ready) begin
                    pending_nxt = pending & ~sel_mask;
                    beat_nxt    = beat + BEAT_W'(1);
                    if (out_last) begin
                        state_nxt   = IDLE;
                        pending_nxt = '0;
                        beat_nxt    = '0;
                        zero_nxt    = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (bus.in_valid && in_ready) begin
            state_nxt   = EMIT;
            pending_nxt = bus.in_vec;
            beat_nxt    = '0;
            zero_nxt    = (bus.in_vec == '0);
        end

        // Abort wins over everything, including a completed beat this cycle.
        if (bus.flush) begin
            state_nxt   = IDLE;
            pending_nxt = '0;
            beat_nxt    = '0;
            zero_nxt    = 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_code  = out_code;
    assign bus.out_last  = out_last;
    assign bus.out_none  = out_none;
    assign bus.out_beat  = out_beat;

endmodule

// File: tb/tb_prio_code_sequencer.sv
// Directed bench for prio_code_sequencer: three configurations driven from one
// linear stimulus sequence, inputs applied at negedge and outputs sampled 1 ns later.
module tb_prio_code_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    prio_code_sequencer_if #(.WIDTH(8),  .CODE_W(3)) b8d ();
    prio_code_sequencer_if #(.WIDTH(8),  .CODE_W(3)) b8a ();
    prio_code_sequencer_if #(.WIDTH(16), .CODE_W(4)) b16 ();

    prio_code_sequencer #(.WIDTH(8),  .CODE_W(3), .DESCENDING(1)) u8d (.clk(clk), .rst(rst), .bus(b8d));
    prio_code_sequencer #(.WIDTH(8),  .CODE_W(3), .DESCENDING(0)) u8a (.clk(clk), .rst(rst), .bus(b8a));
    prio_code_sequencer #(.WIDTH(16), .CODE_W(4), .DESCENDING(1)) u16 (.clk(clk), .rst(rst), .bus(b16));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic exp_d(input string tag, input logic v, input logic [2:0] c,
                         input logic l, input logic n, input logic [3:0] b);
        chk({tag, ".valid"}, 64'(b8d.out_valid), 64'(v));
        chk({tag, ".code"},  64'(b8d.out_code),  64'(c));
        chk({tag, ".last"},  64'(b8d.out_last),  64'(l));
        chk({tag, ".none"},  64'(b8d.out_none),  64'(n));
        chk({tag, ".beat"},  64'(b8d.out_beat),  64'(b));
    endtask

    task automatic exp_a(input string tag, input logic v, input logic [2:0] c,
                         input logic l, input logic [3:0] b);
        chk({tag, ".valid"}, 64'(b8a.out_valid), 64'(v));
        chk({tag, ".code"},  64'(b8a.out_code),  64'(c));
        chk({tag, ".last"},  64'(b8a.out_last),  64'(l));
        chk({tag, ".beat"},  64'(b8a.out_beat),  64'(b));
    endtask

    task automatic exp_w(input string tag, input logic v, input logic [3:0] c,
                         input logic l, input logic [4:0] b);
        chk({tag, ".valid"}, 64'(b16.out_valid), 64'(v));
        chk({tag, ".code"},  64'(b16.out_code),  64'(c));
        chk({tag, ".last"},  64'(b16.out_last),  64'(l));
        chk({tag, ".beat"},  64'(b16.out_beat),  64'(b));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        b8d.flush = 1'b0; b8d.in_valid = 1'b0; b8d.in_vec = '0; b8d.out_ready = 1'b0;
        b8a.flush = 1'b0; b8a.in_valid = 1'b0; b8a.in_vec = '0; b8a.out_ready = 1'b0;
        b16.flush = 1'b0; b16.in_valid = 1'b0; b16.in_vec = '0; b16.out_ready = 1'b0;

        repeat (3) step();
        rst = 1'b0;
        #1;
        exp_d("rst8d", 0, 0, 0, 0, 0);
        chk("rst8d.in_ready", 64'(b8d.in_ready), 64'd1);
        exp_a("rst8a", 0, 0, 0, 0);
        exp_w("rst16", 0, 0, 0, 0);

        // Descending 1010_0110 with continuous ready: 7,5,2,1
        step(); b8d.in_valid = 1; b8d.in_vec = 8'hA6; b8d.out_ready = 1; #1;
        chk("d_acc.in_ready", 64'(b8d.in_ready), 64'd1);
        step(); b8d.in_valid = 0; b8d.in_vec = 8'h00; #1;
        exp_d("d_b0", 1, 7, 0, 0, 0);
        chk("d_b0.in_ready", 64'(b8d.in_ready), 64'd0);
        step(); #1; exp_d("d_b1", 1, 5, 0, 0, 1);
        step(); #1; exp_d("d_b2", 1, 2, 0, 0, 2);
        step(); #1; exp_d("d_b3", 1, 1, 1, 0, 3);
        chk("d_b3.in_ready", 64'(b8d.in_ready), 64'd1);
        step(); #1; exp_d("d_idle", 0, 0, 0, 0, 0);
        chk("d_idle.in_ready", 64'(b8d.in_ready), 64'd1);

        // Zero vector: single none beat
        step(); b8d.in_valid = 1; b8d.in_vec = 8'h00; #1;
        step(); b8d.in_valid = 0; #1;
        exp_d("z_b0", 1, 0, 1, 1, 0);
        step(); #1; exp_d("z_idle", 0, 0, 0, 0, 0);

        // Back-to-back: 0x81 then 0x10 offered on the last beat
        step(); b8d.in_valid = 1; b8d.in_vec = 8'h81; #1;
        step(); b8d.in_valid = 0; b8d.in_vec = 8'h00; #1;
        exp_d("bb_b0", 1, 7, 0, 0, 0);
        step(); b8d.in_valid = 1; b8d.in_vec = 8'h10; #1;
        exp_d("bb_b1", 1, 0, 1, 0, 1);
        chk("bb_b1.in_ready", 64'(b8d.in_ready), 64'd1);
        step(); b8d.in_valid = 0; b8d.in_vec = 8'h00; #1;
        exp_d("bb_c0", 1, 4, 1, 0, 0);
        step(); #1; exp_d("bb_idle", 0, 0, 0, 0, 0);

        // Ascending 1010_0110 with ready pattern 1,0,0,1,1,1: 1,2,(2),(2),5,7
        step(); b8a.in_valid = 1; b8a.in_vec = 8'hA6; #1;
        step(); b8a.in_valid = 0; b8a.in_vec = 8'h00; b8a.out_ready = 1; #1;
        exp_a("a_s0", 1, 1, 0, 0);
        step(); b8a.out_ready = 0; #1; exp_a("a_s1", 1, 2, 0, 1);
        chk("a_s1.in_ready", 64'(b8a.in_ready), 64'd0);
        step(); b8a.out_ready = 0; #1; exp_a("a_s2", 1, 2, 0, 1);
        step(); b8a.out_ready = 1; #1; exp_a("a_s3", 1, 2, 0, 1);
        step(); b8a.out_ready = 1; #1; exp_a("a_s4", 1, 5, 0, 2);
        step(); b8a.out_ready = 1; #1; exp_a("a_s5", 1, 7, 1, 3);
        step(); #1; exp_a("a_idle", 0, 0, 0, 0);
        chk("a_idle.in_ready", 64'(b8a.in_ready), 64'd1);

        // WIDTH=16: 0x8001 -> 15, 0
        step(); b16.in_valid = 1; b16.in_vec = 16'h8001; b16.out_ready = 1; #1;
        step(); b16.in_valid = 0; b16.in_vec = 16'h0000; #1;
        exp_w("w_b0", 1, 15, 0, 0);
        step(); #1; exp_w("w_b1", 1, 0, 1, 1);
        step(); #1; exp_w("w_idle", 0, 0, 0, 0);

        // Flush after two beats of 0xFF; the vector offered in that cycle is refused
        step(); b8d.in_valid = 1; b8d.in_vec = 8'hFF; b8d.out_ready = 1; #1;
        step(); b8d.in_valid = 0; b8d.in_vec = 8'h00; #1;
        exp_d("f_b0", 1, 7, 0, 0, 0);
        step(); #1; exp_d("f_b1", 1, 6, 0, 0, 1);
        step(); b8d.flush = 1; b8d.in_valid = 1; b8d.in_vec = 8'h55; #1;
        exp_d("f_b2", 1, 5, 0, 0, 2);
        chk("f_b2.in_ready", 64'(b8d.in_ready), 64'd0);
        step(); b8d.flush = 0; b8d.in_valid = 0; b8d.in_vec = 8'h00; #1;
        exp_d("f_post", 0, 0, 0, 0, 0);
        chk("f_post.in_ready", 64'(b8d.in_ready), 64'd1);
        step(); #1; exp_d("f_post2", 0, 0, 0, 0, 0);

        // Async reset after the first beat of 0xFF has been taken
        step(); b8d.in_valid = 1; b8d.in_vec = 8'hFF; #1;
        step(); b8d.in_valid = 0; b8d.in_vec = 8'h00; #1;
        exp_d("r_b0", 1, 7, 0, 0, 0);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        exp_d("r_async", 0, 0, 0, 0, 0);
        chk("r_async.in_ready", 64'(b8d.in_ready), 64'd1);
        step(); rst = 1'b0; #1;
        exp_d("r_rel", 0, 0, 0, 0, 0);
        step(); #1; exp_d("r_rel2", 0, 0, 0, 0, 0);
        chk("r_rel2.in_ready", 64'(b8d.in_ready), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
